// File: rtl/svc_rv_pkg.sv
// Shared definitions for the RV pipeline hazard controller.
//   res_src_e   : encoding of the writeback result source carried down the pipe
//   hz_state_e  : hazard controller sequencing states
package svc_rv_pkg;

    typedef enum logic [2:0] {
        RES_ALU  = 3'd0,
        RES_LOAD = 3'd1,
        RES_PC4  = 3'd2,
        RES_IMM  = 3'd3,
        RES_CSR  = 3'd4
    } res_src_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        CSR_WAIT  = 2'd2,
        MDU_BUSY  = 2'd3
    } hz_state_e;

endpackage

// File: rtl/svc_rv_hazard_match.sv
// Register dependency detector for one producing pipeline stage.
//   rs1_i, rs2_i           : source registers of the instruction in ID
//   uses_rs1_i, uses_rs2_i : the ID instruction actually reads that operand
//   rd_i, reg_write_i      : destination and write enable of the producer
//   match_o                : ID depends on the producer's result
module svc_rv_hazard_match (
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       uses_rs1_i,
    input  logic       uses_rs2_i,
    input  logic [4:0] rd_i,
    input  logic       reg_write_i,
    output logic       match_o
);

    // x0 is hard-wired to zero, so a write to it never creates a dependency.
    assign match_o = reg_write_i && (rd_i != 5'd0) &&
                     ((uses_rs1_i && (rs1_i == rd_i)) ||
                      (uses_rs2_i && (rs2_i == rd_i)));

endmodule

// File: rtl/svc_rv_hazard_ctl.sv
// Pipeline hazard controller: load-use and CSR-use stalls, multi-cycle MDU
// hold with watchdog, and branch flush.
//   clk, rst                          : clock, asynchronous active-high reset
//   rs1_id, rs2_id, uses_rs1/rs2_id   : ID-stage operands
//   rd/reg_write/res_src_ex           : EX-stage producer
//   rd/reg_write/res_src_mem          : MEM-stage producer
//   mdu_start_ex, mdu_done            : MDU issue and completion pulse
//   branch_taken_ex                   : redirect resolved in EX
//   stall_if/id/ex                    : hold the stage register
//   bubble_ex/mem                     : insert a NOP into that stage
//   flush_id                          : squash IF/ID
//   stall_cycles                      : saturating count of stall_id cycles
//   mdu_timeout                       : sticky, set when the MDU watchdog fires
module svc_rv_hazard_ctl
    import svc_rv_pkg::*;
#(
    parameter int MEM_TYPE    = 0,
    parameter int MDU_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        uses_rs1_id,
    input  logic        uses_rs2_id,
    input  logic [4:0]  rd_ex,
    input  logic        reg_write_ex,
    input  logic [2:0]  res_src_ex,
    input  logic [4:0]  rd_mem,
    input  logic        reg_write_mem,
    input  logic [2:0]  res_src_mem,
    input  logic        mdu_start_ex,
    input  logic        mdu_done,
    input  logic        branch_taken_ex,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        bubble_ex,
    output logic        bubble_mem,
    output logic        flush_id,
    output logic [31:0] stall_cycles,
    output logic        mdu_timeout
);

    // Extra stall cycles a load needs beyond the first: a registered data
    // memory delivers load data one stage later.
    localparam logic           LOAD_EXTRA = (MEM_TYPE != 0);
    localparam int             CNT_W      = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] MDU_LAST = CNT_W'(MDU_TIMEOUT - 1);

    hz_state_e        state_q, state_d;
    logic             wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic [31:0]      stall_cycles_q, stall_cycles_d;
    logic             mdu_timeout_q, mdu_timeout_d;

    logic match_ex, match_mem;
    logic load_hz, csr_hz;
    logic hold_front, hold_ex, bub_ex, bub_mem, flush, tmo_set;

    svc_rv_hazard_match u_match_ex (
        .rs1_i       (rs1_id),
        .rs2_i       (rs2_id),
        .uses_rs1_i  (uses_rs1_id),
        .uses_rs2_i  (uses_rs2_id),
        .rd_i        (rd_ex),
        .reg_write_i (reg_write_ex),
        .match_o     (match_ex)
    );

    svc_rv_hazard_match u_match_mem (
        .rs1_i       (rs1_id),
        .rs2_i       (rs2_id),
        .uses_rs1_i  (uses_rs1_id),
        .uses_rs2_i  (uses_rs2_id),
        .rd_i        (rd_mem),
        .reg_write_i (reg_write_mem),
        .match_o     (match_mem)
    );

    assign load_hz = match_ex && (res_src_ex == RES_LOAD);
    assign csr_hz  = (match_ex  && (res_src_ex  == RES_CSR)) ||
                     (match_mem && (res_src_mem == RES_CSR));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mdu_cnt_d  = mdu_cnt_q;
        tmo_set    = 1'b0;
        hold_front = 1'b0;
        hold_ex    = 1'b0;
        bub_ex     = 1'b0;
        bub_mem    = 1'b0;
        flush      = 1'b0;

        if (state_q == MDU_BUSY) begin
            // EX is frozen on the MDU op, so a branch seen here is stale and ignored.
            if (mdu_done) begin
                state_d = IDLE;
            end else begin
                hold_front = 1'b1;
                hold_ex    = 1'b1;
                bub_mem    = 1'b1;
                if (mdu_cnt_q == MDU_LAST) begin
                    state_d = IDLE;
                    tmo_set = 1'b1;
                end else begin
                    mdu_cnt_d = mdu_cnt_q + CNT_W'(1);
                end
            end
        end else if (branch_taken_ex) begin
            // The stalled ID instruction is on the wrong path; squash instead of waiting.
            flush      = 1'b1;
            bub_ex     = 1'b1;
            state_d    = IDLE;
            wait_cnt_d = 1'b0;
        end else begin
            case (state_q)
                LOAD_WAIT: begin
                    if (wait_cnt_q) begin
                        hold_front = 1'b1;
                        bub_ex     = 1'b1;
                        wait_cnt_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CSR_WAIT: begin
                    if (csr_hz) begin
                        hold_front = 1'b1;
                        bub_ex     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    if (load_hz) begin
                        hold_front = 1'b1;
                        bub_ex     = 1'b1;
                        state_d    = LOAD_WAIT;
                        wait_cnt_d = LOAD_EXTRA;
                    end else if (csr_hz) begin
                        hold_front = 1'b1;
                        bub_ex     = 1'b1;
                        state_d    = CSR_WAIT;
                    end else if (mdu_start_ex) begin
                        state_d   = MDU_BUSY;
                        mdu_cnt_d = '0;
                    end
                end
            endcase
        end
    end

    // Reset releases every control output immediately, not at the next edge.
    assign stall_if   = hold_front & ~rst;
    assign stall_id   = hold_front & ~rst;
    assign stall_ex   = hold_ex    & ~rst;
    assign bubble_ex  = bub_ex     & ~rst;
    assign bubble_mem = bub_mem    & ~rst;
    assign flush_id   = flush      & ~rst;

    assign stall_cycles_d = (stall_id && (stall_cycles_q != 32'hFFFF_FFFF)) ?
                            stall_cycles_q + 32'd1 : stall_cycles_q;
    assign mdu_timeout_d  = mdu_timeout_q | tmo_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            wait_cnt_q     <= 1'b0;
            mdu_cnt_q      <= '0;
            stall_cycles_q <= '0;
            mdu_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mdu_cnt_q      <= mdu_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            mdu_timeout_q  <= mdu_timeout_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign mdu_timeout  = mdu_timeout_q;

endmodule
